mio_bus_hs: RTL and testbench

- Parametrised successor of the memory-mapped I/O bus decoder. It routes CPU load/store accesses to NSLV peripheral slots, selected by address bits [31:28].
- Unlike the combinational decoder, transfers use a request/ready handshake with registered outputs. Slaves may insert wait states via ack.
- Unmapped or unresponsive accesses end with an error flag, and errors are counted.
- Sits between the CPU data port and RAM/VRAM/GPIO/counter peripherals.

---
 rtl/mio_bus_hs_if.sv | 41 ++++
 rtl/mio_bus_hs.sv | 150 +++++++++++++++
 tb/tb_mio_bus_hs.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mio_bus_hs_if.sv
// mio_bus_hs_if: bundle of the CPU-side and slave-side signals of the MMIO
// handshake bus decoder.
//   slave  modport : the decoder's view (CPU request in, slot strobes out)
//   master modport : the environment's view (CPU and peripherals)
// Signals:
//   cpu_req/cpu_we/cpu_addr/cpu_wdata   CPU access request
//   cpu_rdata/cpu_ready/cpu_err         registered completion
//   slv_sel/slv_we/slv_addr/slv_wdata   latched slot access
//   slv_rdata/slv_ack                   per-slot read data and completion
//   err_cnt                             saturating error counter
interface mio_bus_hs_if #(
    parameter int NSLV = 4,
    parameter int DW   = 32
);
    logic                 cpu_req;
    logic                 cpu_we;
    logic [31:0]          cpu_addr;
    logic [DW-1:0]        cpu_wdata;
    logic [DW-1:0]        cpu_rdata;
    logic                 cpu_ready;
    logic                 cpu_err;
    logic [NSLV-1:0]      slv_sel;
    logic                 slv_we;
    logic [31:0]          slv_addr;
    logic [DW-1:0]        slv_wdata;
    logic [NSLV*DW-1:0]   slv_rdata;
    logic [NSLV-1:0]      slv_ack;
    logic [7:0]           err_cnt;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, slv_rdata, slv_ack,
        output cpu_rdata, cpu_ready, cpu_err, slv_sel, slv_we, slv_addr,
               slv_wdata, err_cnt
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, slv_rdata, slv_ack,
        input  cpu_rdata, cpu_ready, cpu_err, slv_sel, slv_we, slv_addr,
               slv_wdata, err_cnt
    );
endinterface

// File: rtl/mio_bus_hs.sv
// mio_bus_hs: memory-mapped I/O decoder with request/ready handshake.
// Routes a CPU access to one of NSLV slots chosen by addr[31:28], waits for
// the slot's ack (bounded by TIMEOUT cycles) and returns a one-cycle
// registered ready pulse with an error flag. Errors are counted (saturating).
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    mio_bus_hs_if.slave (CPU request/response + slot strobes)
module mio_bus_hs #(
    parameter int                NSLV     = 4,
    parameter int                DW       = 32,
    parameter logic [4*NSLV-1:0] SLV_BASE = {4'hf, 4'he, 4'hd, 4'h0},
    parameter int                TIMEOUT  = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    mio_bus_hs_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t          state_q, state_d;
    logic [NSLV-1:0] sel_q, sel_d;
    logic            we_q, we_d;
    logic [31:0]     addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            ready_q, ready_d;
    logic            err_q, err_d;
    logic [7:0]      timer_q, timer_d;
    logic [7:0]      err_cnt_q, err_cnt_d;

    // Address decode; iterating downwards lets the lowest matching slot win.
    logic [NSLV-1:0] hit_oh;
    logic            hit;
    always_comb begin
        hit_oh = '0;
        hit    = 1'b0;
        for (int i = NSLV - 1; i >= 0; i--) begin
            if (bus.cpu_addr[31:28] == SLV_BASE[4*i +: 4]) begin
                hit_oh    = '0;
                hit_oh[i] = 1'b1;
                hit       = 1'b1;
            end
        end
    end

    // Read data and ack of the selected slot only; other slots are masked.
    logic [DW-1:0] sel_rdata;
    logic          sel_ack;
    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NSLV; i++) begin
            sel_rdata = sel_rdata | (bus.slv_rdata[DW*i +: DW] & {DW{sel_q[i]}});
        end
        sel_ack = |(bus.slv_ack & sel_q);
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        ready_d   = 1'b0;
        err_d     = 1'b0;
        timer_d   = timer_q;
        err_cnt_d = err_cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.cpu_req) begin
                    if (hit) begin
                        sel_d   = hit_oh;
                        we_d    = bus.cpu_we;
                        addr_d  = {4'h0, bus.cpu_addr[27:0]};
                        wdata_d = bus.cpu_wdata;
                        timer_d = '0;
                        state_d = ACCESS;
                    end else begin
                        // Unmapped: respond straight away with an error.
                        ready_d = 1'b1;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            ACCESS: begin
                // Ack wins over a timeout expiring in the same cycle.
                if (sel_ack) begin
                    if (!we_q) rdata_d = sel_rdata;
                    ready_d = 1'b1;
                    sel_d   = '0;
                    we_d    = 1'b0;
                    state_d = RESP;
                end else if (timer_q == 8'(TIMEOUT - 1)) begin
                    ready_d = 1'b1;
                    err_d   = 1'b1;
                    sel_d   = '0;
                    we_d    = 1'b0;
                    state_d = RESP;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            RESP: begin
                // err_q is the cpu_err being presented this cycle.
                if (err_q && err_cnt_q != 8'hff) err_cnt_d = err_cnt_q + 8'd1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            timer_q   <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
            timer_q   <= timer_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.cpu_rdata = rdata_q;
    assign bus.cpu_ready = ready_q;
    assign bus.cpu_err   = err_q;
    assign bus.slv_sel   = sel_q;
    assign bus.slv_we    = we_q;
    assign bus.slv_addr  = addr_q;
    assign bus.slv_wdata = wdata_q;
    assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_mio_bus_hs.sv
// tb_mio_bus_hs: scoreboard bench for mio_bus_hs. dut_a uses the default
// slot map; dut_b has slots 1 and 3 both mapped to 4'hf.
module tb_mio_bus_hs;
    localparam int NSLV = 4;
    localparam int DW   = 32;
    localparam int TO   = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    mio_bus_hs_if #(.NSLV(NSLV), .DW(DW)) ia ();
    mio_bus_hs_if #(.NSLV(NSLV), .DW(DW)) ib ();

    mio_bus_hs #(.NSLV(NSLV), .DW(DW), .SLV_BASE(16'hfed0), .TIMEOUT(TO))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
    mio_bus_hs #(.NSLV(NSLV), .DW(DW), .SLV_BASE(16'hfef0), .TIMEOUT(TO))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        logic [7:0]  cnt;
        int          lat;
        int          issue;
    } exp_t;
    exp_t sb[$];

    // Reference state: what the CPU should see, from the access rules alone.
    logic [31:0] m_rdata = '0;
    logic [7:0]  m_cnt   = '0;

    int          cur_dly = 0;
    logic [3:0]  exp_sel = '0;
    logic        exp_we  = 1'b0;
    logic [31:0] exp_addr = '0;
    logic [31:0] exp_wdata = '0;

    function automatic int slot_of(input logic [31:0] a);
        logic [3:0] base [4];
        base = '{4'h0, 4'hd, 4'he, 4'hf};
        for (int i = 0; i < 4; i++) if (a[31:28] == base[i]) return i;
        return -1;
    endfunction

    // Monitor: every ready pops one expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (ia.cpu_ready) begin
                    if (sb.size() == 0) chk("spurious_ready", 64'(ia.cpu_ready), 64'd0);
                    else begin
                        e = sb.pop_front();
                        chk("cpu_err", 64'(ia.cpu_err), 64'(e.err));
                        chk("cpu_rdata", 64'(ia.cpu_rdata), 64'(e.rdata));
                        chk("err_cnt", 64'(ia.err_cnt), 64'(e.cnt));
                        chk("latency", 64'(cyc - e.issue), 64'(e.lat));
                        chk("resp_sel_we", 64'({ia.slv_sel, ia.slv_we}), 64'd0);
                    end
                end else begin
                    chk("err_without_ready", 64'(ia.cpu_err), 64'd0);
                end
            end
        end
    end

    // Slave models for dut_a: ack after cur_dly wait cycles, plus noise on
    // non-selected ack bits and on all bits outside ACCESS.
    initial begin
        int acc = 0;
        logic [3:0] noise;
        ia.slv_ack = '0;
        forever begin
            @(negedge clk);
            noise = 4'($urandom);
            if (ia.slv_sel != '0) begin
                chk("slv_sel", 64'(ia.slv_sel), 64'(exp_sel));
                chk("slv_we", 64'(ia.slv_we), 64'(exp_we));
                chk("slv_addr", 64'(ia.slv_addr), 64'(exp_addr));
                chk("slv_wdata", 64'(ia.slv_wdata), 64'(exp_wdata));
                ia.slv_ack = (noise & ~ia.slv_sel) | ((acc == cur_dly) ? ia.slv_sel : 4'h0);
                acc++;
            end else begin
                acc = 0;
                ia.slv_ack = noise;
            end
        end
    end

    initial begin
        ib.slv_ack = '0;
        forever begin
            @(negedge clk);
            ib.slv_ack = ib.slv_sel;
        end
    end

    // One access on dut_a; call and return at a negedge.
    task automatic txn(input logic [31:0] a, input logic we, input logic [31:0] wd,
                       input int dly, input logic [31:0] rd);
        int s;
        exp_t e;
        logic [127:0] rdv;
        bit done;
        s = slot_of(a);
        for (int i = 0; i < 4; i++) rdv[32*i +: 32] = $urandom;
        if (s >= 0) rdv[32*s +: 32] = rd;
        ia.slv_rdata = rdv;
        cur_dly   = dly;
        exp_sel   = (s >= 0) ? 4'(1 << s) : 4'h0;
        exp_we    = we;
        exp_addr  = {4'h0, a[27:0]};
        exp_wdata = wd;
        if (s < 0) begin
            e.err = 1'b1; e.lat = 1;
        end else if (dly <= TO - 1) begin
            e.err = 1'b0; e.lat = 2 + dly;
            if (!we) m_rdata = rd;
        end else begin
            e.err = 1'b1; e.lat = TO + 1;
        end
        e.rdata = m_rdata;
        e.cnt   = m_cnt;
        e.issue = cyc;
        if (e.err && m_cnt != 8'hff) m_cnt = m_cnt + 8'd1;
        sb.push_back(e);
        ia.cpu_req = 1'b1; ia.cpu_addr = a; ia.cpu_we = we; ia.cpu_wdata = wd;
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (ia.cpu_ready) done = 1'b1;
            else begin
                // Request fields are sampled once; scrambling them must not matter.
                ia.cpu_addr = $urandom; ia.cpu_wdata = $urandom; ia.cpu_we = 1'($urandom);
            end
        end
        if (!done) chk("ready_timeout", 64'(ia.cpu_ready), 64'd1);
        ia.cpu_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic b_txn(input logic [31:0] a, input logic [3:0] esel, input logic [31:0] erd);
        ib.cpu_req = 1'b1; ib.cpu_addr = a; ib.cpu_we = 1'b0; ib.cpu_wdata = '0;
        @(negedge clk);
        chk("b_slv_sel", 64'(ib.slv_sel), 64'(esel));
        @(negedge clk);
        chk("b_ready", 64'(ib.cpu_ready), 64'd1);
        chk("b_err", 64'(ib.cpu_err), 64'd0);
        chk("b_rdata", 64'(ib.cpu_rdata), 64'(erd));
        ib.cpu_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_ctl"}, 64'({ia.cpu_ready, ia.cpu_err, ia.slv_sel, ia.slv_we, ia.err_cnt}), 64'd0);
        chk({nm, "_rdata"}, 64'(ia.cpu_rdata), 64'd0);
        chk({nm, "_addr"}, 64'(ia.slv_addr), 64'd0);
        chk({nm, "_wdata"}, 64'(ia.slv_wdata), 64'd0);
    endtask

    initial begin
        int di;
        int dlys [9];
        logic [3:0] nib [4];
        logic [31:0] a;
        dlys = '{0, 1, 2, 3, 0, 1, 14, 15, 255};
        nib  = '{4'h0, 4'hd, 4'he, 4'hf};
        ia.cpu_req = 1'b0; ia.cpu_we = 1'b0; ia.cpu_addr = '0; ia.cpu_wdata = '0;
        ia.slv_rdata = '0;
        ib.cpu_req = 1'b0; ib.cpu_we = 1'b0; ib.cpu_addr = '0; ib.cpu_wdata = '0;
        ib.slv_rdata = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases.
        txn(32'h0000_0010, 1'b0, 32'h0, 0, 32'h1234_5678);
        txn(32'hE000_0000, 1'b1, 32'hA5A5_0F0F, 3, 32'hDEAD_0001);
        txn(32'h5000_0000, 1'b0, 32'h0, 0, 32'h0);
        txn(32'hD000_0004, 1'b0, 32'h0, 255, 32'hDEAD_0002);
        txn(32'hD000_0004, 1'b0, 32'h0, 14, 32'hCAFE_BABE);
        txn(32'hF000_0008, 1'b0, 32'h0, 15, 32'hDEAD_0003);

        // Randomized mix.
        for (int n = 0; n < 120; n++) begin
            di = $urandom_range(0, 4);
            if (di < 4) a = {nib[di], 28'($urandom)};
            else a = {4'($urandom_range(1, 12)), 28'($urandom)};
            txn(a, 1'($urandom), $urandom, dlys[$urandom_range(0, 8)], $urandom);
        end

        // Reset in the middle of an access: no ready, everything cleared.
        cur_dly = 255; exp_sel = 4'b0010; exp_we = 1'b0;
        exp_addr = 32'h0000_0004; exp_wdata = 32'h0;
        ia.cpu_req = 1'b1; ia.cpu_addr = 32'hD000_0004; ia.cpu_we = 1'b0; ia.cpu_wdata = '0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0; ia.cpu_req = 1'b0;
        @(negedge clk);
        chk_all_zero("mid_reset");
        rst_n = 1'b1;
        m_cnt = '0; m_rdata = '0;
        repeat (20) @(negedge clk);
        txn(32'h0000_0020, 1'b0, 32'h0, 1, 32'h0BAD_F00D);
        txn(32'h9000_0000, 1'b0, 32'h0, 0, 32'h0);

        // Overlapping slot map on dut_b: lowest index wins.
        b_txn(32'hF000_0000, 4'b0010, 32'h1111_1111);
        b_txn(32'hE000_0000, 4'b0100, 32'h2222_2222);

        // Saturate the error counter.
        for (int n = 0; n < 260; n++) txn({4'h5, 28'($urandom)}, 1'b0, 32'h0, 0, 32'h0);
        @(negedge clk);
        chk("err_cnt_sat", 64'(ia.err_cnt), 64'h00ff);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
